bus_operation: RTL and testbench
================================

# bus_operation

MESI coherence and bus-operation engine for the split L2 cache. It accepts one line-state request per cycle, made of a trace command, an address and the line's current MESI state. It returns the next MESI state, the bus transaction to issue, and the snoop result to drive. It also keeps running counts of issued bus transactions. The block sits between the L2 tag/LRU array and the system bus model.

## Interface
Parameters:
- ADDR_W, 32: address width.
- OFFSET_W, 6: line-offset bits, zeroed on the bus address.
- CNT_W, 32: width of each bus-operation counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_cmd  in  4  0 = L1 data read, 1 = L1 write, 2 = L1 instruction read, 3 = snooped invalidate, 4 = snooped read, 5 = snooped write, 6 = snooped RFO.
- req_addr  in  ADDR_W  request address.
- req_state  in  2  current line state: I = 00, S = 01, E = 10, M = 11.
- rsp_valid  out  1  response strobe.
- rsp_next_state  out  2  next MESI state.
- rsp_bus_op  out  3  bus operation: NONE = 0, READ = 1, WRITE = 2, INVALIDATE = 3, RFO = 4.
- rsp_bus_addr  out  ADDR_W  req_addr with its low OFFSET_W bits cleared.
- rsp_snoop  out  2  snoop result: NOHIT = 00, HIT = 01, HITM = 10.
- rsp_error  out  1  illegal command.
- cnt_read, cnt_write, cnt_rfo, cnt_inval  out  CNT_W each  issued-operation counters.
- l1_inval_valid  out  1  L1 invalidate message strobe.
- l1_inval_addr  out  ADDR_W  line address for the L1 invalidate message.

## Operation
Own-request commands:
- Read (cmd 0 or 2) with state I:
  - Snoop result is taken from req_addr[1:0]: 00 or 01 → NOHIT, 10 → HIT, 11 → HITM.
  - NOHIT → next state E; otherwise → S.
  - bus_op = READ; rsp_snoop carries the sampled snoop result.
- Read with state S, E or M: state unchanged, bus_op = NONE.
- Write (cmd 1) transitions:
  - I → M, bus_op = RFO.
  - S → M, bus_op = INVALIDATE.
  - E → M, bus_op = NONE.
  - M → M, bus_op = NONE.

Snooped commands:
- rsp_snoop gives our put-snoop response: I → NOHIT, M → HITM, S or E → HIT.
- Snooped invalidate (cmd 3): S → I; every other state is unchanged; bus_op = NONE.
- Snooped read (cmd 4):
  - E → S, bus_op = NONE.
  - M → S, bus_op = WRITE (writeback).
  - S and I are unchanged.
- Snooped write (cmd 5): no state change, bus_op = NONE.
- Snooped RFO (cmd 6):
  - M → I, bus_op = WRITE.
  - S or E → I, bus_op = NONE.
  - I stays I.

Illegal commands:
- Any other cmd sets rsp_error = 1.
- State is unchanged and bus_op = NONE.
- No counter changes.

Counters:
- Each non-NONE bus_op increments exactly one counter; INVALIDATE increments cnt_inval.
- Counters wrap modulo 2^CNT_W.

## Timing
- Latency is one cycle: a request sampled at edge N drives rsp_* during cycle N+1. rsp_valid is high for exactly one cycle per request.
- There is no backpressure; back-to-back requests are accepted every cycle.
- Counters update on the same edge that registers the response.
- Reset asynchronously clears every output and counter to 0 (rsp_next_state = I, rsp_bus_op = NONE, rsp_snoop = NOHIT).
- Reset asserted while a request is in flight discards that request.

## Configuration
- BUS_OPERATION_L1_MSG_EN defined:
  - l1_inval_valid pulses alongside rsp_valid whenever a line leaves a valid state for I, or an M line is written back.
  - l1_inval_addr = rsp_bus_addr.
- BUS_OPERATION_L1_MSG_EN undefined: l1_inval_valid and l1_inval_addr are tied to 0.

## Structure
- Package bus_operation_pkg holds:
  - the MESI state, command, bus-op and snoop-result encodings;
  - the get-snoop address decode function.
- Sub-module mesi_next_state is purely combinational. It maps state, cmd and snoop to {next_state, bus_op, snoop, error}.
- The top level registers that result and holds the counters.

## Test plan
- cmd 0, addr 0x0000_1040, state I → next E, bus READ, snoop NOHIT, bus_addr 0x0000_1040, cnt_read = 1.
- cmd 0, addr 0x0000_1042, state I → next S, bus READ, snoop HIT. The same request with addr ending in 11 gives snoop HITM.
- cmd 1 issued as three separate requests with state I, then S, then E:
  - state I → M with RFO;
  - state S → M with INVALIDATE;
  - state E → M with NONE;
  - after all three, cnt_rfo = 1 and cnt_inval = 1.
- cmd 4 on state M → next S, bus WRITE, snoop HITM. With the macro enabled, l1_inval_valid = 1.
- cmd 6 on state E → next I, bus NONE, snoop HIT. cmd 7 on any state → rsp_error = 1, state unchanged.
- Assert rst mid-stream → all outputs and counters read 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/bus_operation_pkg.sv
// ---------------------------------------------------------------------------
// bus_operation_pkg
// Shared encodings for the MESI coherence / bus-operation engine:
//   mesi_e   - line state        (I=00, S=01, E=10, M=11)
//   cmd_e    - trace command     (0..6 legal, anything else is illegal)
//   bus_op_e - bus transaction   (NONE, READ, WRITE, INVALIDATE, RFO)
//   snoop_e  - snoop result      (NOHIT, HIT, HITM)
// get_snoop() models the other caches' response to our bus read; it is
// decoded from the two low address bits.
// ---------------------------------------------------------------------------
package bus_operation_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_e;

  typedef enum logic [3:0] {
    CMD_L1_DRD   = 4'd0,
    CMD_L1_WR    = 4'd1,
    CMD_L1_IRD   = 4'd2,
    CMD_SN_INVAL = 4'd3,
    CMD_SN_RD    = 4'd4,
    CMD_SN_WR    = 4'd5,
    CMD_SN_RFO   = 4'd6
  } cmd_e;

  typedef enum logic [2:0] {
    BUS_NONE  = 3'd0,
    BUS_READ  = 3'd1,
    BUS_WRITE = 3'd2,
    BUS_INVAL = 3'd3,
    BUS_RFO   = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'b00,
    SNOOP_HIT   = 2'b01,
    SNOOP_HITM  = 2'b10
  } snoop_e;

  // Result other caches return for our own bus read: 00/01 -> NOHIT,
  // 10 -> HIT, 11 -> HITM.
  function automatic snoop_e get_snoop(input logic [1:0] addr_lo);
    case (addr_lo)
      2'b10:   return SNOOP_HIT;
      2'b11:   return SNOOP_HITM;
      default: return SNOOP_NOHIT;
    endcase
  endfunction

endpackage

// File: rtl/bus_operation_if.sv
// ---------------------------------------------------------------------------
// bus_operation_if
// Request/response bundle of the bus-operation engine.
//   req_*  : line-state request (valid, cmd, addr, current state)
//   rsp_*  : registered response (next state, bus op, bus addr, snoop, error)
//   cnt_*  : running counts of issued bus operations
//   l1_*   : L1 invalidate message
// Modports: master drives requests (tag/LRU side), slave is the engine.
// ---------------------------------------------------------------------------
interface bus_operation_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) ();
  import bus_operation_pkg::*;

  logic              req_valid;
  logic [3:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  mesi_e             req_state;

  logic              rsp_valid;
  mesi_e             rsp_next_state;
  bus_op_e           rsp_bus_op;
  logic [ADDR_W-1:0] rsp_bus_addr;
  snoop_e            rsp_snoop;
  logic              rsp_error;

  logic [CNT_W-1:0]  cnt_read;
  logic [CNT_W-1:0]  cnt_write;
  logic [CNT_W-1:0]  cnt_rfo;
  logic [CNT_W-1:0]  cnt_inval;

  logic              l1_inval_valid;
  logic [ADDR_W-1:0] l1_inval_addr;

  modport master (
    output req_valid, req_cmd, req_addr, req_state,
    input  rsp_valid, rsp_next_state, rsp_bus_op, rsp_bus_addr, rsp_snoop,
           rsp_error, cnt_read, cnt_write, cnt_rfo, cnt_inval,
           l1_inval_valid, l1_inval_addr
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_state,
    output rsp_valid, rsp_next_state, rsp_bus_op, rsp_bus_addr, rsp_snoop,
           rsp_error, cnt_read, cnt_write, cnt_rfo, cnt_inval,
           l1_inval_valid, l1_inval_addr
  );

endinterface

// File: rtl/bus_operation_mesi_next_state.sv
// ---------------------------------------------------------------------------
// mesi_next_state
// Purely combinational MESI transition table.
//   state_i      : current line state
//   cmd_i        : trace command (raw 4 bits, may be illegal)
//   get_snoop_i  : other caches' response to our bus read
//   next_state_o : next line state
//   bus_op_o     : bus transaction to issue
//   snoop_o      : snoop result to drive (get-snoop on own reads that go to
//                  the bus, put-snoop on snooped commands, NOHIT otherwise)
//   error_o      : illegal command
// ---------------------------------------------------------------------------
module mesi_next_state
  import bus_operation_pkg::*;
(
  input  mesi_e      state_i,
  input  logic [3:0] cmd_i,
  input  snoop_e     get_snoop_i,
  output mesi_e      next_state_o,
  output bus_op_e    bus_op_o,
  output snoop_e     snoop_o,
  output logic       error_o
);

  snoop_e put_snoop;

  always_comb begin
    case (state_i)
      MESI_I:  put_snoop = SNOOP_NOHIT;
      MESI_M:  put_snoop = SNOOP_HITM;
      default: put_snoop = SNOOP_HIT;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch); the case arms only override what changes.
    next_state_o = state_i;
    bus_op_o     = BUS_NONE;
    snoop_o      = SNOOP_NOHIT;
    error_o      = 1'b0;

    case (cmd_i)
      CMD_L1_DRD, CMD_L1_IRD: begin
        if (state_i == MESI_I) begin
          bus_op_o     = BUS_READ;
          snoop_o      = get_snoop_i;
          next_state_o = (get_snoop_i == SNOOP_NOHIT) ? MESI_E : MESI_S;
        end
      end
      CMD_L1_WR: begin
        next_state_o = MESI_M;
        case (state_i)
          MESI_I:  bus_op_o = BUS_RFO;
          MESI_S:  bus_op_o = BUS_INVAL;
          default: bus_op_o = BUS_NONE;
        endcase
      end
      CMD_SN_INVAL: begin
        snoop_o = put_snoop;
        if (state_i == MESI_S) next_state_o = MESI_I;
      end
      CMD_SN_RD: begin
        snoop_o = put_snoop;
        if (state_i == MESI_E) next_state_o = MESI_S;
        if (state_i == MESI_M) begin
          next_state_o = MESI_S;
          bus_op_o     = BUS_WRITE;
        end
      end
      CMD_SN_WR: begin
        snoop_o = put_snoop;
      end
      CMD_SN_RFO: begin
        snoop_o      = put_snoop;
        next_state_o = MESI_I;
        if (state_i == MESI_M) bus_op_o = BUS_WRITE;
      end
      default: begin
        error_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bus_operation.sv
// ---------------------------------------------------------------------------
// bus_operation
// MESI coherence and bus-operation engine. One request per cycle, response
// registered one cycle later; running counters of issued bus operations.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears every output and counter
//   bus  : bus_operation_if.slave (requests in, responses/counters out)
// Optional feature: define BUS_OPERATION_L1_MSG_EN to generate L1 invalidate
// messages; otherwise l1_inval_valid/l1_inval_addr are tied to 0.
// ---------------------------------------------------------------------------
module bus_operation
  import bus_operation_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  bus_operation_if.slave bus
);

  mesi_e             nxt_state;
  bus_op_e           nxt_op;
  snoop_e            nxt_snoop;
  logic              nxt_error;
  logic [ADDR_W-1:0] line_addr;

  assign line_addr = {bus.req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

  mesi_next_state u_mesi_next_state (
    .state_i      (bus.req_state),
    .cmd_i        (bus.req_cmd),
    .get_snoop_i  (get_snoop(bus.req_addr[1:0])),
    .next_state_o (nxt_state),
    .bus_op_o     (nxt_op),
    .snoop_o      (nxt_snoop),
    .error_o      (nxt_error)
  );

  logic              rsp_valid_q;
  mesi_e             rsp_state_q;
  bus_op_e           rsp_op_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  snoop_e            rsp_snoop_q;
  logic              rsp_error_q;
  logic              l1_valid_d, l1_valid_q;

  logic [CNT_W-1:0] cnt_read_d,  cnt_read_q;
  logic [CNT_W-1:0] cnt_write_d, cnt_write_q;
  logic [CNT_W-1:0] cnt_rfo_d,   cnt_rfo_q;
  logic [CNT_W-1:0] cnt_inval_d, cnt_inval_q;

  // Exactly one counter moves per issued operation; counters wrap naturally.
  always_comb begin
    cnt_read_d  = cnt_read_q;
    cnt_write_d = cnt_write_q;
    cnt_rfo_d   = cnt_rfo_q;
    cnt_inval_d = cnt_inval_q;
    if (bus.req_valid) begin
      case (nxt_op)
        BUS_READ:  cnt_read_d  = cnt_read_q  + CNT_W'(1);
        BUS_WRITE: cnt_write_d = cnt_write_q + CNT_W'(1);
        BUS_RFO:   cnt_rfo_d   = cnt_rfo_q   + CNT_W'(1);
        BUS_INVAL: cnt_inval_d = cnt_inval_q + CNT_W'(1);
        default:   ;
      endcase
    end
  end

`ifdef BUS_OPERATION_L1_MSG_EN
  // L1 must drop its copy when the line leaves a valid state for I, or when
  // a modified line is written back.
  assign l1_valid_d = bus.req_valid &&
                      (((bus.req_state != MESI_I) && (nxt_state == MESI_I)) ||
                       ((bus.req_state == MESI_M) && (nxt_op == BUS_WRITE)));
`else
  assign l1_valid_d = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_state_q <= MESI_I;
      rsp_op_q    <= BUS_NONE;
      rsp_addr_q  <= '0;
      rsp_snoop_q <= SNOOP_NOHIT;
      rsp_error_q <= 1'b0;
      l1_valid_q  <= 1'b0;
      cnt_read_q  <= '0;
      cnt_write_q <= '0;
      cnt_rfo_q   <= '0;
      cnt_inval_q <= '0;
    end else begin
      rsp_valid_q <= bus.req_valid;
      l1_valid_q  <= l1_valid_d;
      if (bus.req_valid) begin
        rsp_state_q <= nxt_state;
        rsp_op_q    <= nxt_op;
        rsp_addr_q  <= line_addr;
        rsp_snoop_q <= nxt_snoop;
        rsp_error_q <= nxt_error;
      end
      cnt_read_q  <= cnt_read_d;
      cnt_write_q <= cnt_write_d;
      cnt_rfo_q   <= cnt_rfo_d;
      cnt_inval_q <= cnt_inval_d;
    end
  end

  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_next_state = rsp_state_q;
  assign bus.rsp_bus_op     = rsp_op_q;
  assign bus.rsp_bus_addr   = rsp_addr_q;
  assign bus.rsp_snoop      = rsp_snoop_q;
  assign bus.rsp_error      = rsp_error_q;
  assign bus.cnt_read       = cnt_read_q;
  assign bus.cnt_write      = cnt_write_q;
  assign bus.cnt_rfo        = cnt_rfo_q;
  assign bus.cnt_inval      = cnt_inval_q;
  assign bus.l1_inval_valid = l1_valid_q;
`ifdef BUS_OPERATION_L1_MSG_EN
  assign bus.l1_inval_addr  = rsp_addr_q;
`else
  assign bus.l1_inval_addr  = '0;
`endif

endmodule

// File: tb/tb_bus_operation.sv
// ---------------------------------------------------------------------------
// tb_bus_operation
// Directed-vector bench for bus_operation. Requests are driven on the falling
// edge, responses sampled 1 ns after the rising edge. Expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_bus_operation;
  import bus_operation_pkg::*;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;
`ifdef BUS_OPERATION_L1_MSG_EN
  localparam bit L1_EN = 1'b1;
`else
  localparam bit L1_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bus_operation_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  bus_operation #(.ADDR_W(ADDR_W), .OFFSET_W(6), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one request for one cycle and return 1 ns after the sampling edge.
  task automatic step(input logic [3:0] cmd, input logic [31:0] addr,
                      input mesi_e state);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    bus.req_state = state;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input mesi_e ns, input bus_op_e op,
                           input snoop_e snp, input logic err,
                           input logic [31:0] baddr);
    check({tag, ".valid"}, 64'(bus.rsp_valid), 64'(1));
    check({tag, ".state"}, 64'(bus.rsp_next_state), 64'(ns));
    check({tag, ".op"},    64'(bus.rsp_bus_op), 64'(op));
    check({tag, ".snoop"}, 64'(bus.rsp_snoop), 64'(snp));
    check({tag, ".err"},   64'(bus.rsp_error), 64'(err));
    check({tag, ".addr"},  64'(bus.rsp_bus_addr), 64'(baddr));
  endtask

  task automatic check_cnt(input string tag, input int rd, input int wr,
                           input int rfo, input int inv);
    check({tag, ".cnt_read"},  64'(bus.cnt_read),  64'(rd));
    check({tag, ".cnt_write"}, 64'(bus.cnt_write), 64'(wr));
    check({tag, ".cnt_rfo"},   64'(bus.cnt_rfo),   64'(rfo));
    check({tag, ".cnt_inval"}, 64'(bus.cnt_inval), 64'(inv));
  endtask

  task automatic check_l1(input string tag, input logic expect_msg,
                          input logic [31:0] addr);
    check({tag, ".l1_valid"}, 64'(bus.l1_inval_valid), 64'(L1_EN & expect_msg));
    check({tag, ".l1_addr"},  64'(bus.l1_inval_addr),  L1_EN ? 64'(addr) : 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, ".state"}, 64'(bus.rsp_next_state), 64'(MESI_I));
    check({tag, ".op"},    64'(bus.rsp_bus_op), 64'(BUS_NONE));
    check({tag, ".snoop"}, 64'(bus.rsp_snoop), 64'(SNOOP_NOHIT));
    check({tag, ".err"},   64'(bus.rsp_error), 64'(0));
    check({tag, ".addr"},  64'(bus.rsp_bus_addr), 64'(0));
    check({tag, ".l1v"},   64'(bus.l1_inval_valid), 64'(0));
    check({tag, ".l1a"},   64'(bus.l1_inval_addr), 64'(0));
    check_cnt(tag, 0, 0, 0, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = 4'd0;
    bus.req_addr  = '0;
    bus.req_state = MESI_I;

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Own reads from I: snoop decoded from addr[1:0]
    step(4'd0, 32'h0000_1040, MESI_I);
    check_rsp("rd_nohit", MESI_E, BUS_READ, SNOOP_NOHIT, 1'b0, 32'h0000_1040);
    check_cnt("rd_nohit", 1, 0, 0, 0);
    step(4'd0, 32'h0000_1042, MESI_I);
    check_rsp("rd_hit", MESI_S, BUS_READ, SNOOP_HIT, 1'b0, 32'h0000_1040);
    step(4'd2, 32'h0000_1043, MESI_I);
    check_rsp("ird_hitm", MESI_S, BUS_READ, SNOOP_HITM, 1'b0, 32'h0000_1040);
    check_cnt("ird_hitm", 3, 0, 0, 0);
    step(4'd0, 32'h0000_2001, MESI_I);
    check_rsp("rd_01", MESI_E, BUS_READ, SNOOP_NOHIT, 1'b0, 32'h0000_2000);

    // Own read hitting a valid line
    step(4'd0, 32'h0000_2000, MESI_M);
    check({"rd_m", ".state"}, 64'(bus.rsp_next_state), 64'(MESI_M));
    check({"rd_m", ".op"},    64'(bus.rsp_bus_op), 64'(BUS_NONE));
    check_cnt("rd_m", 4, 0, 0, 0);

    // Writes from I, S, E
    step(4'd1, 32'h0000_3005, MESI_I);
    check_rsp("wr_i", MESI_M, BUS_RFO, SNOOP_NOHIT, 1'b0, 32'h0000_3000);
    step(4'd1, 32'h0000_3005, MESI_S);
    check_rsp("wr_s", MESI_M, BUS_INVAL, SNOOP_NOHIT, 1'b0, 32'h0000_3000);
    step(4'd1, 32'h0000_3005, MESI_E);
    check_rsp("wr_e", MESI_M, BUS_NONE, SNOOP_NOHIT, 1'b0, 32'h0000_3000);
    check_cnt("wr_e", 4, 0, 1, 1);

    // Snooped read of an M line: writeback
    step(4'd4, 32'h0000_40FF, MESI_M);
    check_rsp("snrd_m", MESI_S, BUS_WRITE, SNOOP_HITM, 1'b0, 32'h0000_40C0);
    check_l1("snrd_m", 1'b1, 32'h0000_40C0);
    check_cnt("snrd_m", 4, 1, 1, 1);

    // Snooped RFO on E and M
    step(4'd6, 32'h0000_5080, MESI_E);
    check_rsp("snrfo_e", MESI_I, BUS_NONE, SNOOP_HIT, 1'b0, 32'h0000_5080);
    check_l1("snrfo_e", 1'b1, 32'h0000_5080);
    step(4'd6, 32'h0000_5080, MESI_M);
    check_rsp("snrfo_m", MESI_I, BUS_WRITE, SNOOP_HITM, 1'b0, 32'h0000_5080);
    check_cnt("snrfo_m", 4, 2, 1, 1);
    step(4'd6, 32'h0000_5080, MESI_I);
    check_rsp("snrfo_i", MESI_I, BUS_NONE, SNOOP_NOHIT, 1'b0, 32'h0000_5080);
    check_l1("snrfo_i", 1'b0, 32'h0000_5080);

    // Snooped invalidate, write, read on quiet states
    step(4'd3, 32'h0000_6000, MESI_S);
    check_rsp("sninv_s", MESI_I, BUS_NONE, SNOOP_HIT, 1'b0, 32'h0000_6000);
    check_l1("sninv_s", 1'b1, 32'h0000_6000);
    step(4'd3, 32'h0000_6000, MESI_M);
    check_rsp("sninv_m", MESI_M, BUS_NONE, SNOOP_HITM, 1'b0, 32'h0000_6000);
    check_l1("sninv_m", 1'b0, 32'h0000_6000);
    step(4'd5, 32'h0000_6000, MESI_E);
    check_rsp("snwr_e", MESI_E, BUS_NONE, SNOOP_HIT, 1'b0, 32'h0000_6000);
    step(4'd4, 32'h0000_6000, MESI_E);
    check_rsp("snrd_e", MESI_S, BUS_NONE, SNOOP_HIT, 1'b0, 32'h0000_6000);
    step(4'd4, 32'h0000_6000, MESI_I);
    check_rsp("snrd_i", MESI_I, BUS_NONE, SNOOP_NOHIT, 1'b0, 32'h0000_6000);

    // Illegal commands: state held, error flagged, counters frozen
    step(4'd7, 32'h0000_7000, MESI_E);
    check_rsp("ill7", MESI_E, BUS_NONE, SNOOP_NOHIT, 1'b1, 32'h0000_7000);
    step(4'd15, 32'h0000_7003, MESI_M);
    check_rsp("ill15", MESI_M, BUS_NONE, SNOOP_NOHIT, 1'b1, 32'h0000_7000);
    check_cnt("ill15", 4, 2, 1, 1);

    // rsp_valid is a single-cycle pulse
    idle();
    check("idle.valid", 64'(bus.rsp_valid), 64'(0));
    check("idle.l1v", 64'(bus.l1_inval_valid), 64'(0));
    check_cnt("idle", 4, 2, 1, 1);

    // Asynchronous reset mid-cycle, no edge in between
    step(4'd1, 32'h0000_8000, MESI_I);
    check_cnt("pre_rst", 4, 2, 2, 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");

    // Reset held across an edge with a request pending: it is discarded
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_cmd   = 4'd0;
    bus.req_addr  = 32'h0000_9000;
    bus.req_state = MESI_I;
    @(posedge clk);
    #1;
    check_all_zero("rst_inflight");

    // Normal operation resumes after release
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    step(4'd1, 32'h0000_A0C1, MESI_I);
    check_rsp("post_rst", MESI_M, BUS_RFO, SNOOP_NOHIT, 1'b0, 32'h0000_A0C0);
    check_cnt("post_rst", 0, 0, 1, 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
